hall_gen: RTL and testbench
===========================

HALL_GEN -- requirements
Module: hall_gen

Interface
REQ-001 Parameter: PERIOD_W, 16, width of the step-period input.
REQ-002 Parameter: BLANK, 64, clocks after each hall change during which the gate checker ignores drive pins.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  1 = emulated rotor turns; 0 = freeze the hall state and period counter.
REQ-007 dir  input  1  1 = forward sequence, 0 = reverse sequence.
REQ-008 period  input  PERIOD_W  clocks per hall step; 0 = stalled.
REQ-009 highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu  input  1 each  gate drives observed from the motor driver.
REQ-010 clr_err  input  1  clears the sticky error flags.
REQ-011 hallGrn, hallYlw, hallBlu  output  1 each  registered hall sensor code {Grn,Ylw,Blu}.
REQ-012 pos  output  3  current sequence index, 0..5.
REQ-013 step  output  1  one-cycle pulse in the cycle the hall code changes.
REQ-014 err_shoot  output  1  sticky flag: high and low gate of the same phase were asserted together.
REQ-015 err_off  output  1  sticky flag: the undriven phase had a gate asserted outside the blanking window.

Function
REQ-016 Forward sequence by pos 0..5 SHALL be 101, 100, 110, 010, 011, 001; the code after 001 is 101.
REQ-017 dir=1 SHALL step pos+1 mod 6; dir=0 SHALL step pos-1 mod 6 (0 -> 5).
REQ-018 A free-running counter cnt SHALL increment each cycle while en=1 and period!=0.
REQ-019 When cnt >= period-1, the next edge SHALL step pos, set cnt=0, and assert step for exactly that cycle.
  - With period=N, hall changes occur every N clocks.
  - period=1 steps every cycle.
REQ-020 If period is lowered below the current cnt, the step SHALL occur on the next edge; a raised period SHALL extend the current step.
REQ-021 en=0 or period=0 SHALL hold pos and cnt and keep step=0.
REQ-022 dir and period SHALL be sampled live; a dir change takes effect at the next step and never alters pos on its own.
REQ-023 Hall outputs SHALL be decoded registered from pos, so a hall change and its step pulse appear in the same cycle.
REQ-024 Expected phases per hall code (forward / reverse / off):
  - 101: G / Y / B
  - 100: G / B / Y
  - 110: Y / B / G
  - 010: Y / G / B
  - 011: B / G / Y
  - 001: B / Y / G
REQ-025 A blanking counter SHALL reload to BLANK on every step and decrement to 0; checking of the off phase SHALL be active only when it is 0.
REQ-026 err_off SHALL set when checking is active and the off phase has high or low asserted.
REQ-027 err_shoot SHALL set in any cycle where high and low of any phase are both 1; it is not blanked.
REQ-028 Errors SHALL be registered, so a flag appears one cycle after the offending sample.
REQ-029 Errors SHALL stay set until clr_err or rst; if clr_err coincides with a new violation, set wins.

Reset
REQ-030 On rst, the block SHALL apply the following reset values:
  - pos=0, hall=101, cnt=0, step=0;
  - err_shoot=0, err_off=0;
  - blanking counter loaded to BLANK.
REQ-031 rst SHALL override en, clr_err and all other inputs in the same cycle, including a pending step.

Configuration
REQ-032 Macro HALL_GEN_CHECK_EN defined: the gate checker, with its blanking counter and error flags, SHALL be compiled in as specified.
REQ-033 Macro HALL_GEN_CHECK_EN undefined: err_shoot and err_off SHALL be tied 0 and the gate inputs ignored; the sequencer is unchanged.

Verification
REQ-034 Reset, then en=1, dir=1, period=4 -> hall 101, 100, 110, 010, 011, 001, 101 with 4-clock spacing; one step pulse per change.
REQ-035 At pos=2 set dir=0, period=3 -> next codes 100, 101, 001, each 3 clocks apart.
REQ-036 en=0 for 10 cycles mid-step -> hall and cnt frozen, no step pulse; after en=1 the remaining count completes.
REQ-037 Hall=101 with lowBlu=1 at 10 cycles after the step (BLANK=64) -> err_off stays 0; the same at 70 cycles -> err_off=1 next cycle; clr_err -> 0.
REQ-038 highYlw=lowYlw=1 for one cycle -> err_shoot=1 next cycle and stays set; rst -> 0 and hall returns to 101.
REQ-039 Build without HALL_GEN_CHECK_EN -> rerun the REQ-037/038 stimulus; both error flags stay 0.

Source files
------------

// File: rtl/hall_gen.sv
// rtl/hall_gen.sv - Emulated BLDC hall sensor sequencer with gate-drive checker.
// Optional checker compiled in with HALL_GEN_CHECK_EN; otherwise error flags tie to 0.
module hall_gen #(
    parameter int PERIOD_W = 16,
    parameter int BLANK    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] period,
    input  logic                highGrn,
    input  logic                lowGrn,
    input  logic                highYlw,
    input  logic                lowYlw,
    input  logic                highBlu,
    input  logic                lowBlu,
    input  logic                clr_err,
    output logic                hallGrn,
    output logic                hallYlw,
    output logic                hallBlu,
    output logic [2:0]          pos,
    output logic                step,
    output logic                err_shoot,
    output logic                err_off
);
    localparam int BLANK_W = $clog2(BLANK + 2);

    logic [PERIOD_W-1:0] cnt;
    logic [2:0]          hall;
    logic [2:0]          pos_next;
    logic                run;
    logic                advance;

    function automatic logic [2:0] hall_code(input logic [2:0] p);
        case (p)
            3'd0:    hall_code = 3'b101;
            3'd1:    hall_code = 3'b100;
            3'd2:    hall_code = 3'b110;
            3'd3:    hall_code = 3'b010;
            3'd4:    hall_code = 3'b011;
            3'd5:    hall_code = 3'b001;
            default: hall_code = 3'b101;
        endcase
    endfunction

    // A lowered period leaves cnt above the new limit, so >= forces an immediate step.
    always_comb begin
        run     = en && (period != '0);
        advance = run && (cnt >= period - PERIOD_W'(1));
        if (dir) begin
            pos_next = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
        end else begin
            pos_next = (pos == 3'd0) ? 3'd5 : pos - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos  <= 3'd0;
            cnt  <= '0;
            step <= 1'b0;
            hall <= 3'b101;
        end else begin
            step <= advance;
            if (advance) begin
                pos  <= pos_next;
                cnt  <= '0;
                hall <= hall_code(pos_next);
            end else if (run) begin
                cnt <= cnt + PERIOD_W'(1);
            end
        end
    end

    assign {hallGrn, hallYlw, hallBlu} = hall;

`ifdef HALL_GEN_CHECK_EN
    logic [BLANK_W-1:0] blank;
    logic               off_hi;
    logic               off_lo;
    logic               shoot_now;
    logic               off_now;

    // The undriven phase depends only on the current hall code, not on direction.
    always_comb begin
        off_hi = 1'b0;
        off_lo = 1'b0;
        case (pos)
            3'd0, 3'd3: begin off_hi = highBlu; off_lo = lowBlu; end
            3'd1, 3'd4: begin off_hi = highYlw; off_lo = lowYlw; end
            default:    begin off_hi = highGrn; off_lo = lowGrn; end
        endcase
        shoot_now = (highGrn && lowGrn) || (highYlw && lowYlw) || (highBlu && lowBlu);
        off_now   = (blank == '0) && (off_hi || off_lo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank     <= BLANK_W'(BLANK);
            err_shoot <= 1'b0;
            err_off   <= 1'b0;
        end else begin
            if (advance) begin
                blank <= BLANK_W'(BLANK);
            end else if (blank != '0) begin
                blank <= blank - BLANK_W'(1);
            end
            err_shoot <= shoot_now || (err_shoot && !clr_err);
            err_off   <= off_now || (err_off && !clr_err);
        end
    end
`else
    logic unused_checker;
    assign unused_checker = ^{highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu,
                              clr_err, BLANK_W'(BLANK)};
    assign err_shoot = 1'b0;
    assign err_off   = 1'b0;
`endif

endmodule

// File: tb/tb_hall_gen.sv
// tb/tb_hall_gen.sv - Self-checking bench for hall_gen against a behavioural model.
module tb_hall_gen;
    localparam int BLANK = 64;
`ifdef HALL_GEN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        dir = 1'b1;
    logic [15:0] period = '0;
    logic        highGrn = 0, lowGrn = 0, highYlw = 0, lowYlw = 0, highBlu = 0, lowBlu = 0;
    logic        clr_err = 1'b0;
    logic        hallGrn, hallYlw, hallBlu;
    logic [2:0]  pos;
    logic        step;
    logic        err_shoot, err_off;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    hall_gen #(.PERIOD_W(16), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .period(period),
        .highGrn(highGrn), .lowGrn(lowGrn), .highYlw(highYlw), .lowYlw(lowYlw),
        .highBlu(highBlu), .lowBlu(lowBlu), .clr_err(clr_err),
        .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .pos(pos), .step(step), .err_shoot(err_shoot), .err_off(err_off)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] hall_of(input int p);
        logic [2:0] tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        return tab[p];
    endfunction

    // Off phase index: 0 = G, 1 = Y, 2 = B.
    function automatic int off_phase(input logic [2:0] h);
        case (h)
            3'b101, 3'b010: return 2;
            3'b100, 3'b011: return 1;
            default:        return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int m_pos = 0, m_cnt = 0, m_since = 0, m_op;
    bit m_step = 0, m_es = 0, m_eo = 0, m_adv;
    logic [2:0] g_hi, g_lo;

    always @(posedge clk) begin
        g_hi = {highBlu, highYlw, highGrn};
        g_lo = {lowBlu, lowYlw, lowGrn};
        if (rst) begin
            m_pos = 0; m_cnt = 0; m_since = 0; m_step = 0; m_es = 0; m_eo = 0;
        end else begin
            m_op = off_phase(hall_of(m_pos));
            m_es = (|(g_hi & g_lo)) || (m_es && !clr_err);
            m_eo = ((m_since >= BLANK) && (g_hi[m_op] || g_lo[m_op])) || (m_eo && !clr_err);
            m_adv = en && (period != 0) && (m_cnt + 1 >= int'(period));
            m_step = m_adv;
            if (m_adv) begin
                m_pos = dir ? (m_pos + 1) % 6 : (m_pos + 5) % 6;
                m_cnt = 0;
                m_since = 0;
            end else begin
                if (en && period != 0) m_cnt++;
                if (m_since < BLANK) m_since++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("hall", {hallGrn, hallYlw, hallBlu}, hall_of(m_pos));
            chk("pos", pos, m_pos);
            chk("step", step, m_step);
            chk("err_shoot", err_shoot, CHECK_EN ? m_es : 1'b0);
            chk("err_off", err_off, CHECK_EN ? m_eo : 1'b0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_step(input int budget, output int waited);
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            waited++;
            if (step) return;
        end
        chk("step_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] exp_codes [9];
    int w;

    initial begin
        exp_codes = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b000};
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hall", {hallGrn, hallYlw, hallBlu}, 3'b101);
        chk("rst_pos", pos, 0);
        chk("rst_step", step, 0);
        chk("rst_errs", {err_shoot, err_off}, 0);

        // Forward run at period 4, continuing to pos 2.
        en = 1'b1; dir = 1'b1; period = 16'd4;
        for (int i = 0; i < 8; i++) begin
            wait_step(20, w);
            chk("fwd_code", {hallGrn, hallYlw, hallBlu}, exp_codes[i]);
            chk("fwd_gap", w, 4);
        end
        chk("fwd_pos2", pos, 2);

        // Reverse at period 3.
        dir = 1'b0; period = 16'd3;
        exp_codes[0] = 3'b100; exp_codes[1] = 3'b101; exp_codes[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            wait_step(20, w);
            chk("rev_code", {hallGrn, hallYlw, hallBlu}, exp_codes[i]);
            chk("rev_gap", w, 3);
        end

        // Freeze mid-step: gap grows by exactly the frozen cycles.
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("frz_step", step, 0);
            chk("frz_hall", {hallGrn, hallYlw, hallBlu}, 3'b001);
        end
        en = 1'b1;
        wait_step(20, w);
        chk("frz_gap", w + 11, 13);
        chk("frz_code", {hallGrn, hallYlw, hallBlu}, 3'b011);

        // Blanking window on the off phase (Blu for hall 101).
        en = 1'b0; period = '0; dir = 1'b1;
        do_reset();
        repeat (9) tick();
        lowBlu = 1'b1; tick(); lowBlu = 1'b0;
        chk("blank_in", err_off, 0);
        repeat (60) tick();
        lowBlu = 1'b1; tick(); lowBlu = 1'b0;
        chk("blank_out", err_off, CHECK_EN ? 1 : 0);
        tick();
        chk("off_sticky", err_off, CHECK_EN ? 1 : 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("off_clr", err_off, 0);
        clr_err = 1'b1; lowBlu = 1'b1; tick(); clr_err = 1'b0; lowBlu = 1'b0;
        chk("off_setwins", err_off, CHECK_EN ? 1 : 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // Shoot-through.
        highYlw = 1'b1; lowYlw = 1'b1; tick(); highYlw = 1'b0; lowYlw = 1'b0;
        chk("shoot_set", err_shoot, CHECK_EN ? 1 : 0);
        repeat (3) tick();
        chk("shoot_sticky", err_shoot, CHECK_EN ? 1 : 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("shoot_rst", err_shoot, 0);
        chk("shoot_rst_hall", {hallGrn, hallYlw, hallBlu}, 3'b101);

        // period=1 steps every cycle.
        en = 1'b1; period = 16'd1;
        exp_codes = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("p1_step", step, 1);
            chk("p1_code", {hallGrn, hallYlw, hallBlu}, exp_codes[i]);
        end

        // Period lowered below cnt forces the step on the next edge.
        period = 16'd10;
        repeat (6) tick();
        chk("low_nostep", step, 0);
        period = 16'd3;
        tick();
        chk("low_step", step, 1);
        chk("low_code", {hallGrn, hallYlw, hallBlu}, 3'b100);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 14) == 0)
                period = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(60, 90))
                                                     : 16'($urandom_range(0, 6));
            {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu} = '0;
            highGrn = ($urandom_range(0, 15) == 0);
            lowGrn  = ($urandom_range(0, 15) == 0);
            highYlw = ($urandom_range(0, 15) == 0);
            lowYlw  = ($urandom_range(0, 15) == 0);
            highBlu = ($urandom_range(0, 15) == 0);
            lowBlu  = ($urandom_range(0, 15) == 0);
            clr_err = ($urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
